// File: rtl/memrx_pkg.sv
// rtl/memrx_pkg.sv - shared UART/memory constants and state encoding
// Purpose: definitions shared by the receive capture path and the
//          memory-to-UART transmitter.
// Ports:   none (package).
package memrx_pkg;

  localparam int MEMDEPTH = 2048;
  localparam int ADDR_W   = 11;
  // The capture counter needs one extra bit so that a full 2048-byte
  // message can be represented.
  localparam int CNT_W    = ADDR_W + 1;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP,
    UART_BREAK
  } uart_state_e;

endpackage

// File: rtl/memrx_if.sv
// rtl/memrx_if.sv - host-side control, status and read port of memrx
// Purpose: bundles the host-facing signals of memrx.
// Ports (signals):
//   i_clear      re-arm pulse            i_rd_addr  host read address
//   o_rd_data    registered read data    o_wr_count bytes captured
//   o_done       message complete        o_overrun  sticky overrun flag
//   o_frame_errs saturating framing-error count
interface memrx_if;
  import memrx_pkg::*;

  logic              i_clear;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [7:0]        o_rd_data;
  logic [ADDR_W-1:0] o_wr_count;
  logic              o_done;
  logic              o_overrun;
  logic [7:0]        o_frame_errs;

  modport master (
    output i_clear, i_rd_addr,
    input  o_rd_data, o_wr_count, o_done, o_overrun, o_frame_errs
  );

  modport slave (
    input  i_clear, i_rd_addr,
    output o_rd_data, o_wr_count, o_done, o_overrun, o_frame_errs
  );

endinterface

// File: rtl/memrx_rxuart.sv
// rtl/memrx_rxuart.sv - 8N1 UART receiver with break handling
// Purpose: synchronises the rx pin, detects start bits, samples eight
//          data bits LSB-first at mid-bit and checks the stop bit.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_uart_rx       asynchronous serial input, idles high
//   o_stb, o_data   one-cycle strobe with the received byte
//   o_ferr          one-cycle framing-error pulse
module rxuart
  import memrx_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_stb,
  output logic [7:0] o_data,
  output logic       o_ferr
);

  localparam logic [23:0] HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_M1 = CLOCKS_PER_BAUD - 24'd1;

  logic [1:0]  rx_sync_q;
  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [2:0]  bits_q, bits_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        stb_q, stb_d;
  logic        ferr_q, ferr_d;
  logic        tick;

  assign rx_s = rx_sync_q[1];
  assign tick = (timer_q == 24'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_sync_q <= 2'b11;
      state_q   <= UART_IDLE;
      timer_q   <= 24'd0;
      bits_q    <= 3'd0;
      stb_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_uart_rx};
      state_q   <= state_d;
      timer_q   <= timer_d;
      bits_q    <= bits_d;
      stb_q     <= stb_d;
      ferr_q    <= ferr_d;
    end
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!rx_s) begin
          timer_d = HALF_M1;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (!tick) begin
          timer_d = timer_q - 24'd1;
        end else if (rx_s) begin
          state_d = UART_IDLE;     // line went back high: glitch
        end else begin
          timer_d = FULL_M1;
          bits_d  = 3'd0;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (!tick) begin
          timer_d = timer_q - 24'd1;
        end else begin
          shreg_d = {rx_s, shreg_q[7:1]};
          timer_d = FULL_M1;
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd7) state_d = UART_STOP;
        end
      end
      UART_STOP: begin
        if (!tick) begin
          timer_d = timer_q - 24'd1;
        end else if (rx_s) begin
          stb_d   = 1'b1;
          state_d = UART_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = UART_BREAK;
        end
      end
      UART_BREAK: begin
        // a held-low line reports one error, then waits for idle
        if (rx_s) state_d = UART_IDLE;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  assign o_stb  = stb_q;
  assign o_ferr = ferr_q;
  assign o_data = shreg_q;

endmodule

// File: rtl/memrx.sv
// rtl/memrx.sv - UART receive into a 2048x8 message buffer
// Purpose: captures MSGLEN received bytes in order into on-chip memory
//          and exposes them through a registered read port.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_uart_rx       serial input
//   host            memrx_if.slave: clear, read port and status
module memrx
  import memrx_pkg::*;
#(
  parameter int          CLOCK_RATE_HZ   = 100_000_000,
  parameter int          BAUD_RATE       = 115_200,
  parameter int          MSGLEN          = 1600,
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'(CLOCK_RATE_HZ / BAUD_RATE)
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_uart_rx,
  memrx_if.slave  host
);

  logic             stb, ferr;
  logic [7:0]       rx_data;
  logic [7:0]       mem [0:MEMDEPTH-1];
  logic [7:0]       rd_data_q;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ferrs_q, ferrs_d;
  logic             we;

`ifdef FORMAL
  (* anyseq *) logic       f_stb;
  (* anyseq *) logic       f_ferr;
  (* anyseq *) logic [7:0] f_data;
  assign stb     = f_stb;
  assign ferr    = f_ferr;
  assign rx_data = f_data;
  always_comb assume (!(stb && ferr));
  always_comb assert (wr_count_q <= CNT_W'(MSGLEN));
  always_comb assert (done_q == (wr_count_q == CNT_W'(MSGLEN)));
`else
  rxuart #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_rx (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_uart_rx (i_uart_rx),
    .o_stb     (stb),
    .o_data    (rx_data),
    .o_ferr    (ferr)
  );
`endif

  always_comb begin
    wr_count_d = wr_count_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    ferrs_d    = ferrs_q;
    we         = 1'b0;
    if (host.i_clear) begin
      // clear wins over a coincident strobe; that byte is dropped
      wr_count_d = '0;
      done_d     = 1'b0;
      overrun_d  = 1'b0;
    end else if (stb) begin
      if (!done_q) begin
        we         = 1'b1;
        wr_count_d = wr_count_q + CNT_W'(1);
        done_d     = (wr_count_d == CNT_W'(MSGLEN));
      end else begin
        overrun_d  = 1'b1;
      end
    end
    if (ferr && ferrs_q != 8'hFF) ferrs_d = ferrs_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_count_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ferrs_q    <= 8'd0;
    end else begin
      wr_count_q <= wr_count_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      ferrs_q    <= ferrs_d;
    end
  end

  // Memory and read register are never reset so contents survive reset.
  always_ff @(posedge i_clk) begin
    if (we && !i_reset) mem[wr_count_q[ADDR_W-1:0]] <= rx_data;
    rd_data_q <= mem[host.i_rd_addr];
  end

  // With MSGLEN=2048 the 11-bit view wraps to 0 when full; o_done
  // distinguishes that from an empty buffer.
  assign host.o_wr_count   = wr_count_q[ADDR_W-1:0];
  assign host.o_done       = done_q;
  assign host.o_overrun    = overrun_q;
  assign host.o_frame_errs = ferrs_q;
  assign host.o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_memrx.sv
// tb/tb_memrx.sv - directed self-checking bench for memrx
module tb_memrx;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  int   n_tests = 0;
  int   n_fail  = 0;

  memrx_if host_if ();

  memrx #(
    .CLOCK_RATE_HZ (100_000_000),
    .BAUD_RATE     (10_000_000),
    .MSGLEN        (4)
  ) u_dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_uart_rx (rx),
    .host      (host_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame, 10 clocks per bit; the line is left at the stop value.
  task automatic uart_send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(10);
    end
    rx = stop;
    cycles(10);
  endtask

  task automatic read_chk(input string tag, input logic [10:0] addr, input logic [7:0] exp);
    host_if.i_rd_addr = addr;
    cycles(1);
    check(tag, 16'(host_if.o_rd_data), 16'(exp));
  endtask

  task automatic pulse_clear();
    host_if.i_clear = 1'b1;
    cycles(1);
    host_if.i_clear = 1'b0;
  endtask

  logic [7:0] msg [4];

  initial begin
    msg[0] = 8'hA5; msg[1] = 8'h3C; msg[2] = 8'h00; msg[3] = 8'hFF;
    reset = 1'b1;
    rx = 1'b1;
    host_if.i_clear   = 1'b0;
    host_if.i_rd_addr = '0;
    cycles(3);
    reset = 1'b0;
    check("rst_count",   16'(host_if.o_wr_count),   16'd0);
    check("rst_done",    16'(host_if.o_done),       16'd0);
    check("rst_overrun", 16'(host_if.o_overrun),    16'd0);
    check("rst_ferrs",   16'(host_if.o_frame_errs), 16'd0);
    cycles(5);

    // Four back-to-back bytes fill the message.
    for (int i = 0; i < 4; i++) begin
      uart_send(msg[i], 1'b1);
      check("msg_count", 16'(host_if.o_wr_count), 16'(i + 1));
      check("msg_done",  16'(host_if.o_done),     (i == 3) ? 16'd1 : 16'd0);
    end
    cycles(5);
    for (int i = 0; i < 4; i++) read_chk("msg_read", 11'(i), msg[i]);

    // A fifth byte after done is dropped and flagged.
    uart_send(8'h11, 1'b1);
    cycles(3);
    check("ovr_flag",  16'(host_if.o_overrun),  16'd1);
    check("ovr_count", 16'(host_if.o_wr_count), 16'd4);
    check("ovr_done",  16'(host_if.o_done),     16'd1);
    read_chk("ovr_addr0", 11'd0, 8'hA5);
    pulse_clear();
    check("clr_count",   16'(host_if.o_wr_count), 16'd0);
    check("clr_done",    16'(host_if.o_done),     16'd0);
    check("clr_overrun", 16'(host_if.o_overrun),  16'd0);

    // Short low glitch is rejected as a false start.
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(120);
    check("glitch_count", 16'(host_if.o_wr_count),   16'd0);
    check("glitch_ferrs", 16'(host_if.o_frame_errs), 16'd0);

    // Bad stop bit followed by a held-low line: exactly one error.
    uart_send(8'h55, 1'b0);
    cycles(40);
    rx = 1'b1;
    cycles(10);
    check("brk_ferrs", 16'(host_if.o_frame_errs), 16'd1);
    check("brk_count", 16'(host_if.o_wr_count),   16'd0);
    uart_send(8'h42, 1'b1);
    cycles(3);
    check("brk_next_count", 16'(host_if.o_wr_count), 16'd1);
    read_chk("brk_next_addr0", 11'd0, 8'h42);

    // Reset in the middle of bit 4 of a byte whose data bits are high.
    rx = 1'b0;
    cycles(10);
    rx = 1'b1;
    cycles(45);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("mid_rst_count",   16'(host_if.o_wr_count),   16'd0);
    check("mid_rst_done",    16'(host_if.o_done),       16'd0);
    check("mid_rst_overrun", 16'(host_if.o_overrun),    16'd0);
    check("mid_rst_ferrs",   16'(host_if.o_frame_errs), 16'd0);
    cycles(60);
    check("post_rst_ferrs", 16'(host_if.o_frame_errs), 16'd0);
    uart_send(8'h7E, 1'b1);
    cycles(3);
    check("post_rst_count", 16'(host_if.o_wr_count), 16'd1);
    read_chk("post_rst_addr0", 11'd0, 8'h7E);
    read_chk("mem_kept_addr1", 11'd1, 8'h3C);

    // Clear coincides with the strobe of 0x99: the byte is dropped.
    fork
      uart_send(8'h99, 1'b1);
      begin
        repeat (98) @(posedge clk);
        #1 host_if.i_clear = 1'b1;
        @(posedge clk);
        #1 host_if.i_clear = 1'b0;
      end
    join
    cycles(3);
    check("coll_count", 16'(host_if.o_wr_count), 16'd0);
    check("coll_done",  16'(host_if.o_done),     16'd0);
    read_chk("coll_addr0", 11'd0, 8'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
